// File: rtl/brg_frac_if.sv
// Control/strobe bundle between the fractional baud generator and the Manchester line coder.
interface brg_frac_if #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int FRAME_BITS = 8
);
    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    logic                  en;
    logic                  slew;
    logic [INT_WIDTH-1:0]  div_int;
    logic [FRAC_WIDTH-1:0] div_frac;
    logic                  ce_edge;
    logic                  ce_mid;
    logic                  ce_frame;
    logic [IDX_W-1:0]      bit_idx;

    modport master (
        output en, slew, div_int, div_frac,
        input  ce_edge, ce_mid, ce_frame, bit_idx
    );

    modport slave (
        input  en, slew, div_int, div_frac,
        output ce_edge, ce_mid, ce_frame, bit_idx
    );
endinterface

// File: rtl/brg_frac.sv
// Fractional baud-rate generator: bit-edge, mid-bit and frame strobes for Manchester timing.
// Define BRG_FRAC_DITHER_EN to enable the fractional dithering accumulator.
module brg_frac #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int FRAME_BITS = 8
) (
    input  logic     clk,
    input  logic     rst,
    brg_frac_if.slave bus
);
    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [INT_WIDTH:0] cnt;
    logic [INT_WIDTH-1:0] half;
    logic [IDX_W-1:0]   bit_idx;
    logic               carry;
    logic [INT_WIDTH:0] base;
    logic [INT_WIDTH:0] reload;
    logic               zero;
    logic               live;
    logic               last_bit;

`ifdef BRG_FRAC_DITHER_EN
    logic [FRAC_WIDTH-1:0] acc;
    logic [FRAC_WIDTH:0]   sum;
    assign sum   = {1'b0, acc} + {1'b0, bus.div_frac};
    assign carry = sum[FRAC_WIDTH];
`else
    logic unused_frac;
    assign unused_frac = ^bus.div_frac;
    assign carry       = 1'b0;
`endif

    // One extra bit keeps div_int = all-ones plus carry from wrapping.
    assign base     = {1'b0, bus.div_int};
    assign reload   = base + {{INT_WIDTH{1'b0}}, carry};
    assign zero     = (cnt == '0);
    assign live     = (state == RUN) && bus.en && !bus.slew;
    assign last_bit = (bit_idx == IDX_W'(FRAME_BITS - 1));

    assign bus.ce_edge  = live && zero;
    assign bus.ce_mid   = live && (cnt == {1'b0, half});
    assign bus.ce_frame = live && zero && last_bit;
    assign bus.bit_idx  = bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            half    <= '0;
            bit_idx <= '0;
`ifdef BRG_FRAC_DITHER_EN
            acc     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bit_idx <= '0;
`ifdef BRG_FRAC_DITHER_EN
                    acc     <= '0;
`endif
                    if (bus.en) begin
                        state <= RUN;
                        cnt   <= base;
                        half  <= base[INT_WIDTH:1];
                    end else begin
                        cnt   <= '0;
                        half  <= '0;
                    end
                end
                RUN: begin
                    if (!bus.en) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        half    <= '0;
                        bit_idx <= '0;
`ifdef BRG_FRAC_DITHER_EN
                        acc     <= '0;
`endif
                    end else if (bus.slew) begin
                        // Restart the current bit; the pending carry is dropped.
                        cnt  <= base;
                        half <= base[INT_WIDTH:1];
`ifdef BRG_FRAC_DITHER_EN
                        acc  <= '0;
`endif
                    end else if (zero) begin
                        cnt     <= reload;
                        half    <= reload[INT_WIDTH:1];
                        bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
`ifdef BRG_FRAC_DITHER_EN
                        acc     <= sum[FRAC_WIDTH-1:0];
`endif
                    end else begin
                        cnt <= cnt - (INT_WIDTH + 1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brg_frac.sv
// Directed bench for brg_frac: timing, dithering, slew, enable drop and async reset.
module tb_brg_frac;
`ifdef BRG_FRAC_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    brg_frac_if #(.INT_WIDTH(16), .FRAC_WIDTH(4), .FRAME_BITS(8)) b1 ();
    brg_frac_if #(.INT_WIDTH(4),  .FRAC_WIDTH(4), .FRAME_BITS(3)) b2 ();

    brg_frac #(.INT_WIDTH(16), .FRAC_WIDTH(4), .FRAME_BITS(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
    brg_frac #(.INT_WIDTH(4),  .FRAC_WIDTH(4), .FRAME_BITS(3)) u2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    logic       e, m, f, e2, f2;
    logic [2:0] idx;
    logic [1:0] idx2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; outputs captured on the falling edge.
    task automatic cyc(input bit s);
        b1.slew = s;
        @(negedge clk);
        e = b1.ce_edge; m = b1.ce_mid; f = b1.ce_frame; idx = b1.bit_idx;
        e2 = b2.ce_edge; f2 = b2.ce_frame; idx2 = b2.bit_idx;
        @(posedge clk);
        #1;
        b1.slew = 1'b0;
    endtask

    task automatic period1(output int n);
        n = 0;
        do begin cyc(1'b0); n++; end while (!e && n < 200);
    endtask

    task automatic period2(output int n);
        n = 0;
        do begin cyc(1'b0); n++; end while (!e2 && n < 100);
    endtask

    task automatic go_idle();
        b1.en = 1'b0;
        cyc(1'b0);
        chk("idle_drop", 32'({e, m, f}), 32'd0);
        cyc(1'b0);
        chk("idle_idx", 32'({e, m, f, idx}), 32'd0);
    endtask

    initial begin
        int n, sum, mids;
        int p[1:100];
        int exp2 [4];
        b1.en = 1'b0; b1.slew = 1'b0; b1.div_int = 16'd9; b1.div_frac = 4'd0;
        b2.en = 1'b0; b2.slew = 1'b0; b2.div_int = 4'd15; b2.div_frac = 4'd15;
        #12;
        chk("rst_async", 32'({b1.ce_edge, b1.ce_mid, b1.ce_frame, b1.bit_idx}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0);
        chk("rst_state", 32'({e, m, f, idx}), 32'd0);

        // Integer divisor 9: 10-cycle bits, mid on 6th, frame every 80.
        b1.en = 1'b1;
        cyc(1'b0);
        chk("t1_entry", 32'({e, m, f}), 32'd0);
        for (int c = 1; c <= 160; c++) begin
            cyc(1'b0);
            chk("t1", 32'({e, m, f, idx}),
                32'({c % 10 == 0, c % 10 == 6, c % 80 == 0, 3'(((c - 1) / 10) % 8)}));
        end
        go_idle();

        // Zero divisor: both strobes every cycle; en drop at cnt=0 gates them.
        b1.div_int = 16'd0;
        b1.en = 1'b1;
        cyc(1'b0);
        for (int c = 1; c <= 16; c++) begin
            cyc(1'b0);
            chk("t3", 32'({e, m, f, idx}), 32'({1'b1, 1'b1, c % 8 == 0, 3'((c - 1) % 8)}));
        end
        go_idle();

        // Half-bit fractional divisor.
        b1.div_int = 16'd9; b1.div_frac = 4'd8;
        b1.en = 1'b1;
        cyc(1'b0);
        period1(n);
        chk("t2_p0", 32'(n), 32'd10);
        sum = 0;
        for (int k = 1; k <= 100; k++) begin
            period1(p[k]);
            sum += p[k];
        end
        chk("t2_p1", 32'(p[1]), 32'd10);
        chk("t2_p2", 32'(p[2]), DITH ? 32'd11 : 32'd10);
        chk("t2_p3", 32'(p[3]), 32'd10);
        chk("t2_sum100", 32'(sum), DITH ? 32'd1050 : 32'd1000);
        go_idle();

        // Slew at cnt=3 then at cnt=0.
        b1.div_frac = 4'd0;
        b1.en = 1'b1;
        cyc(1'b0);
        period1(n);
        chk("t4_p0", 32'(n), 32'd10);
        for (int c = 1; c <= 6; c++) cyc(1'b0);
        chk("t4_mid", 32'({e, m, idx}), 32'({1'b0, 1'b1, 3'd1}));
        cyc(1'b1);
        chk("t4_slew3", 32'({e, m, f, idx}), 32'({3'b000, 3'd1}));
        for (int c = 1; c <= 9; c++) begin
            cyc(1'b0);
            chk("t4_a", 32'({e, m, idx}), 32'({1'b0, c == 6, 3'd1}));
        end
        cyc(1'b1);
        chk("t4_slew0", 32'({e, m, f, idx}), 32'({3'b000, 3'd1}));
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0);
            chk("t4_b", 32'({e, m, idx}), 32'({c == 10, c == 6, 3'd1}));
        end
        cyc(1'b0);
        chk("t4_idx", 32'(idx), 32'd2);
        go_idle();

        // en drop at cnt=5, re-raised 3 cycles later.
        b1.en = 1'b1;
        cyc(1'b0);
        period1(n);
        chk("t5_p0", 32'(n), 32'd10);
        for (int c = 1; c <= 4; c++) cyc(1'b0);
        b1.en = 1'b0;
        cyc(1'b0);
        chk("t5_drop", 32'({e, m, f, idx}), 32'({3'b000, 3'd1}));
        cyc(1'b0);
        chk("t5_idle1", 32'({e, m, f, idx}), 32'd0);
        cyc(1'b0);
        chk("t5_idle2", 32'({e, m, f, idx}), 32'd0);
        b1.en = 1'b1;
        cyc(1'b0);
        chk("t5_entry", 32'({e, m, f, idx}), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0);
            chk("t5_run", 32'({e, m, idx}), 32'({c == 10, c == 6, 3'd0}));
        end
        go_idle();

        // Narrow instance: all-ones divisor with carry, 3-bit frames.
        exp2 = DITH ? '{16, 16, 17, 17} : '{16, 16, 16, 16};
        b2.en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 4; k++) begin
            period2(n);
            chk("t6_period", 32'(n), 32'(exp2[k]));
            chk("t6_frame", 32'({f2, idx2}), 32'({k % 3 == 2, 2'(k % 3)}));
        end
        b2.en = 1'b0;
        cyc(1'b0);

        // Wide all-ones divisor, then async reset while ce_mid is high.
        b1.div_int = 16'hFFFF; b1.div_frac = 4'd15;
        b1.en = 1'b1;
        cyc(1'b0);
        mids = 0;
        for (int c = 1; c <= 32768; c++) begin
            cyc(1'b0);
            if (m || e) mids++;
        end
        chk("t7_quiet", 32'(mids), 32'd0);
        @(negedge clk);
        chk("t7_mid", 32'({b1.ce_edge, b1.ce_mid}), 32'b01);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst", 32'({b1.ce_edge, b1.ce_mid, b1.ce_frame, b1.bit_idx}), 32'd0);
        b1.div_int = 16'd9; b1.div_frac = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0);
        chk("t7_idle", 32'({e, m, f, idx}), 32'd0);
        period1(n);
        chk("t7_restart", 32'(n), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
